// File: rtl/valid_skew_pkg.sv
// ============================================================================
// Module      : valid_skew_pkg
// Description : Shared types and constants for the valid_skew_ctrl block.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package valid_skew_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        RUN   = 2'd2
    } state_t;

    localparam int VC_W = 3;

    localparam logic [VC_W-1:0] CODE_LOAD = 3'b001;
    localparam logic [VC_W-1:0] CODE_NONE = 3'b000;

endpackage

`default_nettype wire

// File: rtl/valid_skew_cell.sv
// ============================================================================
// Module      : valid_skew_cell
// Description : One MAC's registered valid_ctrl field for the diagonal wavefront.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module valid_skew_cell
    import valid_skew_pkg::*;
#(
    parameter int CNT_W = 4,
    parameter int LEN_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run_i,
    input  logic [CNT_W-1:0] cnt_i,
    input  logic [CNT_W-1:0] offset_i,
    input  logic [LEN_W-1:0] len_i,
    input  logic [VC_W-1:0]  code_i,
    output logic [VC_W-1:0]  field_o
);

    localparam int XW = CNT_W + 1;

    logic [XW-1:0]   cnt_x;
    logic [XW-1:0]   lo;
    logic [XW-1:0]   hi;
    logic            active;
    logic [VC_W-1:0] field_d;
    logic [VC_W-1:0] field_q;

    // One extra bit so offset+len cannot overflow; hi is exclusive.
    assign cnt_x   = {1'b0, cnt_i};
    assign lo      = {1'b0, offset_i};
    assign hi      = lo + XW'(len_i);
    assign active  = run_i && (cnt_x >= lo) && (cnt_x < hi);
    assign field_d = active ? code_i : CODE_NONE;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            field_q <= CODE_NONE;
        end else begin
            field_q <= field_d;
        end
    end

    assign field_o = field_q;

endmodule

`default_nettype wire

// File: rtl/valid_skew_ctrl.sv
// ============================================================================
// Module      : valid_skew_ctrl
// Description : Sequences a skewed valid_ctrl wavefront across a ROWSxCOLS MAC
//               array. Optional abort input when VALID_SKEW_ABORT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module valid_skew_ctrl
    import valid_skew_pkg::*;
#(
    parameter int ROWS  = 2,
    parameter int COLS  = 2,
    parameter int N_MAX = 8
) (
    input  logic                         clk,
    input  logic                         rst,
`ifdef VALID_SKEW_ABORT_EN
    input  logic                         abort,
`endif
    input  logic                         start,
    input  logic                         load_ready,
    input  logic [$clog2(N_MAX+1)-1:0]   len,
    input  logic [2:0]                   code,
    output logic [3*ROWS*COLS-1:0]       valid_ctrl,
    output logic                         busy,
    output logic                         done
);

    localparam int LEN_W = $clog2(N_MAX + 1);
    localparam int CNT_W = $clog2(N_MAX + ROWS + COLS);

    localparam logic [LEN_W-1:0] LEN_SAT = LEN_W'(N_MAX);
    localparam logic [CNT_W-1:0] T_ADJ   = CNT_W'(ROWS + COLS - 3);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [VC_W-1:0]   code_q, code_d;
    logic              done_q, done_d;

    logic              abort_req;
    logic [LEN_W-1:0]  len_in_sat;
    logic [CNT_W-1:0]  cnt_last;
    logic              run_en;

`ifdef VALID_SKEW_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    assign len_in_sat = (len > LEN_SAT) ? LEN_SAT : len;
    // Last count of a pass is T-1 = len + ROWS + COLS - 3 (len is nonzero in RUN).
    assign cnt_last   = CNT_W'(len_q) + T_ADJ;
    assign run_en     = (state_q == RUN) && !abort_req;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        code_d  = code_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = ARMED;
                    len_d   = len_in_sat;
                    code_d  = code;
                end
            end
            ARMED: begin
                if (load_ready) begin
                    cnt_d = '0;
                    if (len_q == '0) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (cnt_q == cnt_last) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        if (abort_req) begin
            state_d = IDLE;
            cnt_d   = '0;
            len_d   = len_q;
            code_d  = code_q;
            done_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            len_q   <= '0;
            code_q  <= CODE_NONE;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            code_q  <= code_d;
            done_q  <= done_d;
        end
    end

    assign busy = (state_q != IDLE);
    assign done = done_q;

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        for (genvar c = 0; c < COLS; c++) begin : g_col
            localparam int IDX = r * COLS + c;

            valid_skew_cell #(
                .CNT_W (CNT_W),
                .LEN_W (LEN_W)
            ) u_cell (
                .clk      (clk),
                .rst      (rst),
                .run_i    (run_en),
                .cnt_i    (cnt_q),
                .offset_i (CNT_W'(r + c)),
                .len_i    (len_q),
                .code_i   (code_q),
                .field_o  (valid_ctrl[VC_W*IDX +: VC_W])
            );
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_valid_skew_ctrl.sv
// ============================================================================
// Module      : tb_valid_skew_ctrl
// Description : Scoreboard bench for valid_skew_ctrl; abort scenarios run when
//               VALID_SKEW_ABORT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_valid_skew_ctrl;

    localparam int ROWS  = 2;
    localparam int COLS  = 3;
    localparam int N_MAX = 8;
    localparam int LEN_W = $clog2(N_MAX + 1);
    localparam int VCW   = 3 * ROWS * COLS;

    logic             clk;
    logic             rst;
    logic             abort;
    logic             start;
    logic             load_ready;
    logic [LEN_W-1:0] len;
    logic [2:0]       code;
    logic [VCW-1:0]   valid_ctrl;
    logic             busy;
    logic             done;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic [VCW-1:0] vc;
        logic           busy;
        logic           done;
    } exp_t;

    exp_t exp_q[$];

    valid_skew_ctrl #(
        .ROWS  (ROWS),
        .COLS  (COLS),
        .N_MAX (N_MAX)
    ) dut (
        .clk        (clk),
        .rst        (rst),
`ifdef VALID_SKEW_ABORT_EN
        .abort      (abort),
`endif
        .start      (start),
        .load_ready (load_ready),
        .len        (len),
        .code       (code),
        .valid_ctrl (valid_ctrl),
        .busy       (busy),
        .done       (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int sat_len(input int l);
        return (l > N_MAX) ? N_MAX : l;
    endfunction

    // Output k cycles after launch: MAC at diagonal d is live for k in [d+1, d+len].
    function automatic logic [VCW-1:0] wave(input int k, input int l, input logic [2:0] cd);
        logic [VCW-1:0] v;
        v = '0;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                if (k >= r + c + 1 && k <= r + c + l)
                    v[3*(r*COLS+c) +: 3] = cd;
            end
        end
        return v;
    endfunction

    // Reference model: pass-level view (idle / armed / k cycles into a pass).
    bit         m_armed = 1'b0;
    bit         m_run   = 1'b0;
    int         m_k     = 0;
    int         m_len   = 0;
    logic [2:0] m_code  = 3'b000;

    always @(posedge clk) begin : model
        exp_t e;
        int   k;
        e.vc   = '0;
        e.busy = 1'b0;
        e.done = 1'b0;
        if (rst || abort) begin
            m_armed = 1'b0;
            m_run   = 1'b0;
        end else if (m_run) begin
            k    = m_k + 1;
            m_k  = k;
            e.vc = wave(k, m_len, m_code);
            if (k == m_len + ROWS + COLS - 2) begin
                e.done = 1'b1;
                m_run  = 1'b0;
            end else begin
                e.busy = 1'b1;
            end
        end else if (m_armed) begin
            if (load_ready) begin
                m_armed = 1'b0;
                if (m_len == 0) begin
                    e.done = 1'b1;
                end else begin
                    m_run  = 1'b1;
                    m_k    = 0;
                    e.busy = 1'b1;
                end
            end else begin
                e.busy = 1'b1;
            end
        end else if (start) begin
            m_armed = 1'b1;
            m_len   = sat_len(int'(len));
            m_code  = code;
            e.busy  = 1'b1;
        end
        exp_q.push_back(e);
    end

    // Clock edges pop the scoreboard; a reset rising mid-cycle is checked at once.
    always @(posedge clk or posedge rst) begin : monitor
        exp_t e;
        #1;
        checks++;
        if (clk) begin
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_empty cyc=%0d: no expected entry for DUT output", cyc);
            end else begin
                e = exp_q.pop_front();
                if (valid_ctrl !== e.vc || busy !== e.busy || done !== e.done) begin
                    errors++;
                    $display("FAIL cycle_out cyc=%0d: got vc=%h busy=%b done=%b, want vc=%h busy=%b done=%b",
                             cyc, valid_ctrl, busy, done, e.vc, e.busy, e.done);
                end
            end
        end else begin
            if (valid_ctrl !== '0 || busy !== 1'b0 || done !== 1'b0) begin
                errors++;
                $display("FAIL async_rst cyc=%0d: got vc=%h busy=%b done=%b, want all zero",
                         cyc, valid_ctrl, busy, done);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic noise();
        start = 1'($urandom_range(0, 1));
        len   = LEN_W'($urandom);
        code  = 3'($urandom);
    endtask

    // Ends on the negedge of the done cycle so a caller may start back-to-back.
    task automatic pass(input int l, input logic [2:0] cd, input int gap);
        int t;
        t = sat_len(l);
        t = (t == 0) ? 0 : t + ROWS + COLS - 2;
        start = 1'b1;
        len   = LEN_W'(l);
        code  = cd;
        step();
        start = 1'b0;
        repeat (gap) begin
            noise();
            step();
        end
        start      = 1'b0;
        load_ready = 1'b1;
        step();
        load_ready = 1'b0;
        repeat (t) begin
            noise();
            step();
        end
        start = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        abort      = 1'b0;
        start      = 1'b0;
        load_ready = 1'b0;
        len        = '0;
        code       = 3'b000;
        repeat (2) step();
        rst = 1'b0;
        step();

        pass(4, 3'b001, 2);
        repeat (2) step();

        pass(0, 3'b101, 1);
        step();

        // start with load_ready in the same cycle must not launch
        start      = 1'b1;
        load_ready = 1'b1;
        len        = LEN_W'(3);
        code       = 3'b110;
        step();
        start      = 1'b0;
        load_ready = 1'b0;
        repeat (8) step();
        load_ready = 1'b1;
        step();
        load_ready = 1'b0;
        repeat (3 + ROWS + COLS - 2) step();

        pass(4, 3'b011, 0);
        pass(2, 3'b111, 1);
        step();

        // reset during the cnt==2 cycle of a len=4 pass
        start = 1'b1;
        len   = LEN_W'(4);
        code  = 3'b001;
        step();
        start      = 1'b0;
        load_ready = 1'b1;
        step();
        load_ready = 1'b0;
        repeat (2) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        repeat (2) step();
        pass(4, 3'b001, 2);
        step();

`ifdef VALID_SKEW_ABORT_EN
        start = 1'b1;
        len   = LEN_W'(5);
        code  = 3'b010;
        step();
        start      = 1'b0;
        load_ready = 1'b1;
        step();
        load_ready = 1'b0;
        step();
        abort = 1'b1;
        start = 1'b1;
        step();
        abort = 1'b0;
        start = 1'b0;
        repeat (3) step();

        start = 1'b1;
        step();
        start      = 1'b0;
        abort      = 1'b1;
        load_ready = 1'b1;
        step();
        abort      = 1'b0;
        load_ready = 1'b0;
        repeat (3) step();
`endif

        pass(15, 3'b001, 1);
        step();

        repeat (25) begin
            pass(int'($urandom_range(0, 15)), 3'($urandom), int'($urandom_range(0, 3)));
            if ($urandom_range(0, 1) == 1)
                repeat ($urandom_range(1, 3)) step();
        end

        repeat (3) step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
